// File: rtl/fetch_next_pc.sv
// Instruction-fetch stage beside the PC register: fetches the word at pc_atual,
// hands it to decode, and drives the next PC, waiting for the PC register to
// reflect it before issuing the following fetch.
module fetch_next_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_atual,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instrucao,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic [31:0] prox_instrucao,
  output logic        pc_update
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_HOLD   = 2'd2,
    S_WAITPC = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            imem_req_q, imem_req_d;
  logic [XLEN-1:0] imem_addr_q, imem_addr_d;
  logic            instr_valid_q, instr_valid_d;
  logic [XLEN-1:0] instrucao_q, instrucao_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic [XLEN-1:0] prox_q, prox_d;
  logic            pc_update_q, pc_update_d;
  logic            redirect_pend_q, redirect_pend_d;
  logic [XLEN-1:0] redirect_tgt_q, redirect_tgt_d;

  logic [XLEN-1:0] branch_tgt_c;
  logic [XLEN-1:0] seq_pc_c;
  logic [XLEN-1:0] req_tgt_c;

  // Word-aligned redirect, sequential successor (wraps mod 2^32), and the
  // redirect used when a fetch completes: a same-cycle pulse is the newest.
  assign branch_tgt_c = branch_target & 32'hFFFF_FFFC;
  assign seq_pc_c     = instr_pc_q + XLEN'(PC_STEP);
  assign req_tgt_c    = branch_taken ? branch_tgt_c : redirect_tgt_q;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a redirect in S_WAITPC defers the PC compare a cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_REQ;
      S_REQ:    if (imem_ready) begin
                  state_d = (redirect_pend_q || branch_taken) ? S_WAITPC : S_HOLD;
                end
      S_HOLD:   if (instr_ready || branch_taken) state_d = S_WAITPC;
      S_WAITPC: if (!branch_taken && (pc_atual == prox_q)) state_d = S_REQ;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and redirect bookkeeping.
  always_comb begin
    imem_req_d      = imem_req_q;
    imem_addr_d     = imem_addr_q;
    instr_valid_d   = instr_valid_q;
    instrucao_d     = instrucao_q;
    instr_pc_d      = instr_pc_q;
    prox_d          = prox_q;
    pc_update_d     = 1'b0;
    redirect_pend_d = redirect_pend_q;
    redirect_tgt_d  = redirect_tgt_q;
    case (state_q)
      S_IDLE: begin
        imem_addr_d = pc_atual;
        imem_req_d  = 1'b1;
      end
      S_REQ: begin
        if (imem_ready) begin
          imem_req_d  = 1'b0;
          instrucao_d = imem_rdata;
          instr_pc_d  = imem_addr_q;
          if (redirect_pend_q || branch_taken) begin
            prox_d          = req_tgt_c;
            pc_update_d     = 1'b1;
            redirect_pend_d = 1'b0;
          end else begin
            instr_valid_d = 1'b1;
          end
        end else if (branch_taken) begin
          redirect_pend_d = 1'b1;
          redirect_tgt_d  = branch_tgt_c;
        end
      end
      S_HOLD: begin
        if (instr_ready || branch_taken) begin
          instr_valid_d = 1'b0;
          pc_update_d   = 1'b1;
          prox_d        = branch_taken ? branch_tgt_c : seq_pc_c;
        end
      end
      S_WAITPC: begin
        if (branch_taken) begin
          prox_d      = branch_tgt_c;
          pc_update_d = 1'b1;
        end else if (pc_atual == prox_q) begin
          imem_addr_d = pc_atual;
          imem_req_d  = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers; reset abandons any in-flight fetch.
  always_ff @(posedge clock) begin
    if (reset) begin
      imem_req_q      <= 1'b0;
      imem_addr_q     <= '0;
      instr_valid_q   <= 1'b0;
      instrucao_q     <= '0;
      instr_pc_q      <= '0;
      prox_q          <= RESET_PC;
      pc_update_q     <= 1'b0;
      redirect_pend_q <= 1'b0;
      redirect_tgt_q  <= '0;
    end else begin
      imem_req_q      <= imem_req_d;
      imem_addr_q     <= imem_addr_d;
      instr_valid_q   <= instr_valid_d;
      instrucao_q     <= instrucao_d;
      instr_pc_q      <= instr_pc_d;
      prox_q          <= prox_d;
      pc_update_q     <= pc_update_d;
      redirect_pend_q <= redirect_pend_d;
      redirect_tgt_q  <= redirect_tgt_d;
    end
  end

  assign imem_req       = imem_req_q;
  assign imem_addr      = imem_addr_q;
  assign instr_valid    = instr_valid_q;
  assign instrucao      = instrucao_q;
  assign instr_pc       = instr_pc_q;
  assign prox_instrucao = prox_q;
  assign pc_update      = pc_update_q;

endmodule

// File: tb/tb_fetch_next_pc.sv
// Bench for fetch_next_pc: models the PC register (configurable lag) and the
// instruction memory (configurable latency); expected instructions and next-PC
// values are queued per scenario and popped as the DUT produces them.
module tb_fetch_next_pc;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_atual = RESET_PC;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic [31:0] instrucao;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic [31:0] prox_instrucao;
  logic        pc_update;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_pc[$];
  logic [31:0] exp_prox[$];

  int pc_lag = 1;
  int pc_cnt = 0;
  int mem_lat = 0;
  int mem_cnt = 0;
  bit mem_force = 1'b0;

  fetch_next_pc #(.RESET_PC(RESET_PC), .PC_STEP(4)) dut (
    .clock(clock), .reset(reset), .pc_atual(pc_atual),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instrucao(instrucao),
    .instr_pc(instr_pc), .instr_ready(instr_ready),
    .prox_instrucao(prox_instrucao), .pc_update(pc_update)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // PC register: latches prox_instrucao pc_lag half-to-whole cycles after pc_update.
  always begin
    @(negedge clock); #1;
    if (reset) begin
      pc_atual = RESET_PC;
      pc_cnt = 0;
    end else begin
      if (pc_update) pc_cnt = pc_lag;
      if (pc_cnt > 0) begin
        pc_cnt--;
        if (pc_cnt == 0) pc_atual = prox_instrucao;
      end
    end
  end

  // Instruction memory: answers after mem_lat waiting cycles of imem_req.
  always begin
    @(negedge clock); #1;
    if (mem_force) begin
      imem_ready = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
    end else if (!reset && imem_req) begin
      if (mem_cnt >= mem_lat) begin
        imem_ready = 1'b1;
        imem_rdata = mem_word(imem_addr);
      end else begin
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        mem_cnt++;
      end
    end else begin
      imem_ready = 1'b0;
      imem_rdata = 32'h0;
      mem_cnt = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time exhausted");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; instr_ready = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; mem_force = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_imem_req got %b need 0", imem_req); end
    tests_run++; if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_imem_addr got %h need 0", imem_addr); end
    tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_instr_valid got %b need 0", instr_valid); end
    tests_run++; if (instrucao !== 32'h0) begin tests_failed++; $display("FAIL reset_instrucao got %h need 0", instrucao); end
    tests_run++; if (instr_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_instr_pc got %h need 0", instr_pc); end
    tests_run++; if (pc_update !== 1'b0) begin tests_failed++; $display("FAIL reset_pc_update got %b need 0", pc_update); end
    tests_run++; if (prox_instrucao !== RESET_PC) begin tests_failed++; $display("FAIL reset_prox got %h need %h", prox_instrucao, RESET_PC); end
  endtask

  task automatic test_sequential();
    logic [31:0] e;
    pc_lag = 1; mem_lat = 0;
    do_reset();
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_pc.push_back(32'(4 * k));
      exp_prox.push_back(32'(4 * k + 4));
    end
    for (int cyc = 0; cyc < 60 && (exp_pc.size() + exp_prox.size()) != 0; cyc++) begin
      @(negedge clock);
      if (instr_valid && instr_ready) begin
        tests_run++;
        if (exp_pc.size() == 0) begin tests_failed++; $display("FAIL seq_instr unexpected pc=%h", instr_pc); end
        else begin
          e = exp_pc.pop_front();
          if (instr_pc !== e || instrucao !== mem_word(e)) begin
            tests_failed++; $display("FAIL seq_instr got pc=%h word=%h need pc=%h word=%h", instr_pc, instrucao, e, mem_word(e));
          end
        end
      end
      if (pc_update) begin
        tests_run++;
        if (exp_prox.size() == 0) begin tests_failed++; $display("FAIL seq_prox unexpected update %h", prox_instrucao); end
        else begin
          e = exp_prox.pop_front();
          if (prox_instrucao !== e) begin tests_failed++; $display("FAIL seq_prox got %h need %h", prox_instrucao, e); end
        end
      end
    end
    if ((exp_pc.size() + exp_prox.size()) != 0) begin
      tests_run++; tests_failed++;
      $display("FAIL seq_timeout pending instr=%0d prox=%0d need 0", exp_pc.size(), exp_prox.size());
      exp_pc.delete(); exp_prox.delete();
    end
  endtask

  task automatic test_pc_lag();
    logic [31:0] e;
    int upd_at = -1;
    bit req_prev = 1'b0;
    bit gap_checked = 1'b0;
    pc_lag = 10; mem_lat = 0;
    do_reset();
    instr_ready = 1'b1;
    exp_pc.push_back(32'h0); exp_pc.push_back(32'h4);
    exp_prox.push_back(32'h4); exp_prox.push_back(32'h8);
    for (int cyc = 0; cyc < 100 && (exp_pc.size() + exp_prox.size()) != 0; cyc++) begin
      @(negedge clock);
      if (imem_req && !req_prev && upd_at >= 0) begin
        tests_run++; gap_checked = 1'b1;
        if (cyc - upd_at != 10) begin tests_failed++; $display("FAIL lag_fetch_gap got %0d need 10", cyc - upd_at); end
        upd_at = -1;
      end
      req_prev = imem_req;
      if (instr_valid && instr_ready) begin
        tests_run++;
        if (exp_pc.size() == 0) begin tests_failed++; $display("FAIL lag_instr unexpected pc=%h", instr_pc); end
        else begin
          e = exp_pc.pop_front();
          if (instr_pc !== e || instrucao !== mem_word(e)) begin
            tests_failed++; $display("FAIL lag_instr got pc=%h word=%h need pc=%h word=%h", instr_pc, instrucao, e, mem_word(e));
          end
        end
      end
      if (pc_update) begin
        upd_at = cyc;
        tests_run++;
        if (exp_prox.size() == 0) begin tests_failed++; $display("FAIL lag_prox unexpected update %h", prox_instrucao); end
        else begin
          e = exp_prox.pop_front();
          if (prox_instrucao !== e) begin tests_failed++; $display("FAIL lag_prox got %h need %h", prox_instrucao, e); end
        end
      end
    end
    if ((exp_pc.size() + exp_prox.size()) != 0 || !gap_checked) begin
      tests_run++; tests_failed++;
      $display("FAIL lag_timeout pending instr=%0d prox=%0d gap_seen=%0d need 0 0 1", exp_pc.size(), exp_prox.size(), gap_checked);
      exp_pc.delete(); exp_prox.delete();
    end
  endtask

  task automatic test_mem_stall();
    logic [31:0] e, req_addr, held_word, held_pc;
    int req_cycles = 0;
    int valid_cycles = 0;
    pc_lag = 1; mem_lat = 5;
    do_reset();
    exp_pc.push_back(32'h0); exp_prox.push_back(32'h4);
    for (int cyc = 0; cyc < 60 && (exp_pc.size() + exp_prox.size()) != 0; cyc++) begin
      @(negedge clock);
      if (imem_req) begin
        if (req_cycles == 0) req_addr = imem_addr;
        else begin
          tests_run++;
          if (imem_addr !== req_addr) begin tests_failed++; $display("FAIL stall_addr_stable got %h need %h", imem_addr, req_addr); end
        end
        req_cycles++;
      end
      instr_ready = 1'b0;
      if (instr_valid) begin
        if (valid_cycles == 0) begin held_word = instrucao; held_pc = instr_pc; end
        else begin
          tests_run++;
          if (instrucao !== held_word || instr_pc !== held_pc) begin
            tests_failed++; $display("FAIL stall_hold_stable got %h@%h need %h@%h", instrucao, instr_pc, held_word, held_pc);
          end
        end
        instr_ready = (valid_cycles >= 3) ? 1'b1 : 1'b0;
        valid_cycles++;
      end
      if (instr_valid && instr_ready) begin
        tests_run++;
        if (exp_pc.size() == 0) begin tests_failed++; $display("FAIL stall_instr unexpected pc=%h", instr_pc); end
        else begin
          e = exp_pc.pop_front();
          if (instr_pc !== e || instrucao !== mem_word(e)) begin
            tests_failed++; $display("FAIL stall_instr got pc=%h word=%h need pc=%h word=%h", instr_pc, instrucao, e, mem_word(e));
          end
        end
      end
      if (pc_update) begin
        tests_run++;
        if (exp_prox.size() == 0) begin tests_failed++; $display("FAIL stall_prox unexpected update %h", prox_instrucao); end
        else begin
          e = exp_prox.pop_front();
          if (prox_instrucao !== e) begin tests_failed++; $display("FAIL stall_prox got %h need %h", prox_instrucao, e); end
        end
      end
    end
    if ((exp_pc.size() + exp_prox.size()) != 0) begin
      tests_run++; tests_failed++;
      $display("FAIL stall_timeout pending instr=%0d prox=%0d need 0", exp_pc.size(), exp_prox.size());
      exp_pc.delete(); exp_prox.delete();
    end
    tests_run++; if (req_cycles != 6) begin tests_failed++; $display("FAIL stall_req_cycles got %0d need 6", req_cycles); end
    tests_run++; if (valid_cycles != 4) begin tests_failed++; $display("FAIL stall_valid_cycles got %0d need 4", valid_cycles); end
    instr_ready = 1'b0;
  endtask

  task automatic test_branch_req();
    logic [31:0] e;
    bit branched = 1'b0;
    bit seen_update = 1'b0;
    bit early_valid = 1'b0;
    pc_lag = 1; mem_lat = 3;
    do_reset();
    instr_ready = 1'b1;
    exp_prox.push_back(32'h100); exp_prox.push_back(32'h104);
    exp_pc.push_back(32'h100);
    for (int cyc = 0; cyc < 80 && (exp_pc.size() + exp_prox.size()) != 0; cyc++) begin
      @(negedge clock);
      branch_taken = 1'b0;
      if (imem_req && !branched) begin
        branch_taken = 1'b1; branch_target = 32'h103; branched = 1'b1;
      end
      if (instr_valid && !seen_update) early_valid = 1'b1;
      if (instr_valid && instr_ready) begin
        tests_run++;
        if (exp_pc.size() == 0) begin tests_failed++; $display("FAIL breq_instr unexpected pc=%h", instr_pc); end
        else begin
          e = exp_pc.pop_front();
          if (instr_pc !== e || instrucao !== mem_word(e)) begin
            tests_failed++; $display("FAIL breq_instr got pc=%h word=%h need pc=%h word=%h", instr_pc, instrucao, e, mem_word(e));
          end
        end
      end
      if (pc_update) begin
        seen_update = 1'b1;
        tests_run++;
        if (exp_prox.size() == 0) begin tests_failed++; $display("FAIL breq_prox unexpected update %h", prox_instrucao); end
        else begin
          e = exp_prox.pop_front();
          if (prox_instrucao !== e) begin tests_failed++; $display("FAIL breq_prox got %h need %h", prox_instrucao, e); end
        end
      end
    end
    branch_taken = 1'b0;
    if ((exp_pc.size() + exp_prox.size()) != 0) begin
      tests_run++; tests_failed++;
      $display("FAIL breq_timeout pending instr=%0d prox=%0d need 0", exp_pc.size(), exp_prox.size());
      exp_pc.delete(); exp_prox.delete();
    end
    tests_run++; if (early_valid) begin tests_failed++; $display("FAIL breq_discard instr_valid rose before redirect, got 1 need 0"); end
  endtask

  task automatic test_branch_hold();
    logic [31:0] e;
    int k = 0;
    pc_lag = 1; mem_lat = 0;
    do_reset();
    instr_ready = 1'b1;
    exp_pc.push_back(32'h0);    exp_pc.push_back(32'h20);   exp_pc.push_back(32'h80);
    exp_prox.push_back(32'h20); exp_prox.push_back(32'h80); exp_prox.push_back(32'h84);
    for (int cyc = 0; cyc < 80 && (exp_pc.size() + exp_prox.size()) != 0; cyc++) begin
      @(negedge clock);
      branch_taken = 1'b0;
      if (instr_valid) begin
        if (k == 0) begin branch_taken = 1'b1; branch_target = 32'h20; end
        if (k == 1) begin branch_taken = 1'b1; branch_target = 32'h80; end
        k++;
      end
      if (instr_valid && instr_ready) begin
        tests_run++;
        if (exp_pc.size() == 0) begin tests_failed++; $display("FAIL bhold_instr unexpected pc=%h", instr_pc); end
        else begin
          e = exp_pc.pop_front();
          if (instr_pc !== e || instrucao !== mem_word(e)) begin
            tests_failed++; $display("FAIL bhold_instr got pc=%h word=%h need pc=%h word=%h", instr_pc, instrucao, e, mem_word(e));
          end
        end
      end
      if (pc_update) begin
        tests_run++;
        if (exp_prox.size() == 0) begin tests_failed++; $display("FAIL bhold_prox unexpected update %h", prox_instrucao); end
        else begin
          e = exp_prox.pop_front();
          if (prox_instrucao !== e) begin tests_failed++; $display("FAIL bhold_prox got %h need %h", prox_instrucao, e); end
        end
      end
    end
    branch_taken = 1'b0;
    if ((exp_pc.size() + exp_prox.size()) != 0) begin
      tests_run++; tests_failed++;
      $display("FAIL bhold_timeout pending instr=%0d prox=%0d need 0", exp_pc.size(), exp_prox.size());
      exp_pc.delete(); exp_prox.delete();
    end
  endtask

  task automatic test_wrap_reset();
    logic [31:0] e;
    int k = 0;
    bit found = 1'b0;
    pc_lag = 1; mem_lat = 0;
    do_reset();
    instr_ready = 1'b1;
    exp_pc.push_back(32'h0);          exp_pc.push_back(32'hFFFF_FFFC); exp_pc.push_back(32'h0);
    exp_prox.push_back(32'hFFFF_FFFC); exp_prox.push_back(32'h0);      exp_prox.push_back(32'h40);
    for (int phase = 0; phase < 2; phase++) begin
      for (int cyc = 0; cyc < 80 && (exp_pc.size() + exp_prox.size()) != 0; cyc++) begin
        @(negedge clock);
        branch_taken = 1'b0;
        if (instr_valid && phase == 0) begin
          if (k == 0) begin branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; end
          if (k == 2) begin branch_taken = 1'b1; branch_target = 32'h40; end
          k++;
        end
        if (instr_valid && instr_ready) begin
          tests_run++;
          if (exp_pc.size() == 0) begin tests_failed++; $display("FAIL wrap_instr unexpected pc=%h", instr_pc); end
          else begin
            e = exp_pc.pop_front();
            if (instr_pc !== e || instrucao !== mem_word(e)) begin
              tests_failed++; $display("FAIL wrap_instr got pc=%h word=%h need pc=%h word=%h", instr_pc, instrucao, e, mem_word(e));
            end
          end
        end
        if (pc_update) begin
          tests_run++;
          if (exp_prox.size() == 0) begin tests_failed++; $display("FAIL wrap_prox unexpected update %h", prox_instrucao); end
          else begin
            e = exp_prox.pop_front();
            if (prox_instrucao !== e) begin tests_failed++; $display("FAIL wrap_prox got %h need %h", prox_instrucao, e); end
          end
        end
      end
      branch_taken = 1'b0;
      if ((exp_pc.size() + exp_prox.size()) != 0) begin
        tests_run++; tests_failed++;
        $display("FAIL wrap_timeout phase=%0d pending instr=%0d prox=%0d need 0", phase, exp_pc.size(), exp_prox.size());
        exp_pc.delete(); exp_prox.delete();
      end
      if (phase == 0) begin
        // Park 0x40 in S_HOLD, then reset with a stale memory response forced on.
        instr_ready = 1'b0;
        for (int cyc = 0; cyc < 30 && !found; cyc++) begin
          @(negedge clock);
          if (instr_valid) found = 1'b1;
        end
        tests_run++;
        if (!found || instr_pc !== 32'h40) begin tests_failed++; $display("FAIL hold_before_reset got valid=%b pc=%h need 1 00000040", found, instr_pc); end
        reset = 1'b1; mem_force = 1'b1;
        @(negedge clock);
        tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_hold_valid got %b need 0", instr_valid); end
        tests_run++; if (prox_instrucao !== RESET_PC) begin tests_failed++; $display("FAIL rst_hold_prox got %h need %h", prox_instrucao, RESET_PC); end
        tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL rst_hold_req got %b need 0", imem_req); end
        reset = 1'b0;
        @(negedge clock);
        tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL stale_ready_valid got %b need 0", instr_valid); end
        mem_force = 1'b0;
        instr_ready = 1'b1;
        exp_pc.push_back(32'h0); exp_prox.push_back(32'h4);
      end
    end
    instr_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_pc_lag();
    test_mem_stall();
    test_branch_req();
    test_branch_hold();
    test_wrap_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_next_pc.md
Name: fetch_next_pc

Overview:
- Instruction-fetch stage, sitting directly beside the PC register.
- Takes the current PC value (pc_atual) and fetches the instruction word from instruction memory over a req/ready handshake.
- Presents the word to decode over a valid/ready handshake.
- Computes the next PC (sequential +4 or branch/jump redirect) and drives it on prox_instrucao, which the PC register latches.
- Waits until the PC register reflects the new address before issuing the next fetch, so it tolerates any PC update period.

Parameters:
- RESET_PC, 32'h00000000, value of prox_instrucao after reset; must match the PC register's reset address.
- PC_STEP, 4, byte increment for sequential fetch.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- pc_atual  in  32  current PC from the PC register.
- branch_taken  in  1  one-cycle redirect pulse from execute.
- branch_target  in  32  redirect address, valid when branch_taken=1.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address, registered.
- imem_ready  in  1  memory has data on imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  instrucao/instr_pc valid for decode.
- instrucao  out  32  fetched instruction word.
- instr_pc  out  32  address of instrucao.
- instr_ready  in  1  decode accepts this cycle.
- prox_instrucao  out  32  next PC to the PC register.
- pc_update  out  1  one-cycle pulse when prox_instrucao takes a new value.

Behaviour:
- Reset (sync, highest priority, also mid-operation):
  - state=S_IDLE.
  - imem_req=0, imem_addr=0, instr_valid=0, instrucao=0, instr_pc=0, pc_update=0.
  - prox_instrucao=RESET_PC; redirect_pend=0.
  - Any in-flight fetch is abandoned; an imem_ready arriving later is ignored.
- S_IDLE:
  - One cycle only, so the PC register settles.
  - Then imem_addr<=pc_atual, imem_req<=1, go to S_REQ.
- S_REQ:
  - imem_req and imem_addr are held stable until imem_ready=1.
  - On imem_ready: imem_req<=0, instrucao<=imem_rdata, instr_pc<=imem_addr.
  - If redirect_pend or branch_taken this cycle: the fetched word is discarded (instr_valid stays 0), prox_instrucao<=target, pc_update<=1, redirect_pend<=0, go to S_WAITPC.
  - Otherwise: instr_valid<=1, go to S_HOLD.
- S_HOLD:
  - instr_valid=1; instrucao and instr_pc held stable until instr_ready=1.
  - On instr_ready: instr_valid<=0, pc_update<=1, go to S_WAITPC. prox_instrucao<=branch_target if branch_taken this cycle (branch wins a simultaneous event, instruction still counts as consumed), else instr_pc+PC_STEP.
  - On branch_taken without instr_ready: instr_valid<=0 (instruction squashed), prox_instrucao<=branch_target, pc_update<=1, go to S_WAITPC.
- S_WAITPC:
  - When pc_atual==prox_instrucao: imem_addr<=pc_atual, imem_req<=1, go to S_REQ.
  - On branch_taken here: prox_instrucao<=branch_target, pc_update<=1, stay in S_WAITPC. The compare that cycle uses the old prox_instrucao value.
- branch_taken in S_REQ before imem_ready: latched as redirect_pend, along with a registered target copy; a later pulse overwrites the copy.
- branch_taken in S_IDLE: ignored.
- Arithmetic:
  - instr_pc+PC_STEP wraps modulo 2^32 (32'hFFFFFFFC -> 0).
  - branch_target[1:0] is forced to 2'b00 before use.
- pc_update is high for exactly one cycle per prox_instrucao write.
- Latency, zero-wait memory and decode: S_IDLE/S_WAITPC -> S_REQ 1 cycle, data captured 1 cycle later, instr_valid high the following cycle.
- At most one instruction is outstanding; no buffering beyond the single instruction register.

Test Plan:
- Reset, pc_atual follows prox_instrucao after 1 cycle, imem_ready=1 immediately, instr_ready=1 -> fetches at 0x0, 0x4, 0x8 in order; instrucao/instr_pc match memory; prox_instrucao steps 0x4, 0x8, 0xC with one pc_update pulse each.
- PC register lags 10 cycles behind prox_instrucao -> imem_req stays 0 throughout S_WAITPC; the fetch issues on the cycle after pc_atual==prox_instrucao.
- imem_ready delayed 5 cycles, then instr_ready held low 3 cycles -> imem_addr/imem_req stable while waiting; instrucao/instr_valid stable while held; no duplicate or lost instruction.
- branch_taken with target 0x103 during S_REQ -> fetched word discarded, instr_valid never rises, prox_instrucao=0x100; next fetch at 0x100.
- branch_taken together with instr_ready in S_HOLD at instr_pc 0x20, target 0x80 -> instruction consumed, prox_instrucao=0x80 (not 0x24).
- instr_pc=0xFFFFFFFC accepted -> prox_instrucao=0x00000000; reset asserted in S_HOLD -> instr_valid=0 and prox_instrucao=RESET_PC next cycle; a stale imem_ready afterwards is ignored.
